// File: rtl/priority_arbiter_4_pkg.sv
// priority_arbiter_4_pkg: shared state encoding and requester count for the arbiter
package priority_arbiter_4_pkg;
    localparam int NUM_REQ = 4;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/priority_arbiter_4_pri_enc_4.sv
// pri_enc_4: combinational highest-set-bit encoder, bit 3 wins
module pri_enc_4 (
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       valid
);
    always_comb idx = vec[3] ? 2'd3 : vec[2] ? 2'd2 : vec[1] ? 2'd1 : 2'd0;
    assign valid = |vec;
endmodule

// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4: fixed-priority 4-way arbiter with hold timeout and one-shot masking
module priority_arbiter_4
    import priority_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);
    state_t state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [NUM_REQ-1:0] mask, mask_n, masked, eff, gnt_n;
    logic [1:0] enc_idx, id_n;
    logic enc_valid, to_n, last;
    assign masked = req & ~mask;
    assign eff = |masked ? masked : req;
    assign last = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    pri_enc_4 u_enc (
        .vec(eff),
        .idx(enc_idx),
        .valid(enc_valid)
    );
    always_comb begin
        state_n = state;
        hold_n = hold_cnt;
        mask_n = mask;
        gnt_n = gnt;
        id_n = gnt_id;
        to_n = 1'b0;
        if (state == IDLE) begin
            if (enc_valid) begin
                state_n = GRANT;
                gnt_n = NUM_REQ'(1) << enc_idx;
                id_n = enc_idx;
                hold_n = '0;
                mask_n = '0;
            end
        end else if (!req[gnt_id]) begin
            state_n = IDLE;
            gnt_n = '0;
        end else if (last) begin
            state_n = IDLE;
            gnt_n = '0;
            mask_n[gnt_id] = 1'b1;
            to_n = 1'b1;
        end else begin
            hold_n = hold_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold_cnt <= '0;
            mask <= '0;
            gnt <= '0;
            gnt_id <= '0;
            gnt_valid <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            hold_cnt <= hold_n;
            mask <= mask_n;
            gnt <= gnt_n;
            gnt_id <= id_n;
            gnt_valid <= |gnt_n;
            timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_priority_arbiter_4.sv
// tb_priority_arbiter_4: directed and random checks against an ownership-level reference model
module tb_priority_arbiter_4;
    localparam int MAX_HOLD = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic gnt_valid, timeout;
    int total = 0;
    int bad = 0;
    int m_owner = -1;
    int m_cycles = 0;
    bit m_mask [4];
    logic [3:0] m_gnt = 4'b0000;
    logic [1:0] m_id = 2'd0;
    logic m_to = 1'b0;

    priority_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_edge(input logic [3:0] r, input logic rs);
        int pick;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_cycles = 0;
            foreach (m_mask[i]) m_mask[i] = 1'b0;
            m_gnt = 4'b0000;
            m_id = 2'd0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int i = 3; i >= 0; i--) if (pick < 0 && r[i] && !m_mask[i]) pick = i;
            for (int i = 3; i >= 0; i--) if (pick < 0 && r[i]) pick = i;
            if (pick >= 0) begin
                m_owner = pick;
                m_cycles = 1;
                foreach (m_mask[i]) m_mask[i] = 1'b0;
                m_gnt = 4'b0000;
                m_gnt[pick] = 1'b1;
                m_id = 2'(pick);
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
            m_gnt = 4'b0000;
        end else if (MAX_HOLD != 0 && m_cycles == MAX_HOLD) begin
            m_mask[m_owner] = 1'b1;
            m_owner = -1;
            m_gnt = 4'b0000;
            m_to = 1'b1;
        end else begin
            m_cycles++;
        end
    endfunction

    task automatic step(input logic [3:0] r, input logic rs);
        req = r;
        reset = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
    endtask

    task automatic test_reset;
        step(4'b0000, 1'b1);
        total++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 8'b0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b id=%0d v=%b to=%b exp all zero", gnt, gnt_id, gnt_valid, timeout);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0);
            total++;
            if ({gnt, gnt_valid, timeout} !== 6'b0) begin
                bad++;
                $display("FAIL idle_quiet cyc=%0d got gnt=%b v=%b to=%b exp zero", i, gnt, gnt_valid, timeout);
            end
        end
    endtask

    task automatic test_two_req;
        logic [3:0] seq [6] = '{4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
        logic [5:0] exp [6] = '{{4'b0100, 2'd2}, {4'b0100, 2'd2}, {4'b0100, 2'd2},
                                {4'b0000, 2'd2}, {4'b0001, 2'd0}, {4'b0000, 2'd0}};
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b0);
            total++;
            if ({gnt, gnt_id} !== exp[i] || gnt_valid !== |exp[i][5:2] || timeout !== 1'b0) begin
                bad++;
                $display("FAIL two_req cyc=%0d got gnt=%b id=%0d v=%b to=%b exp gnt=%b id=%0d",
                         i, gnt, gnt_id, gnt_valid, timeout, exp[i][5:2], exp[i][1:0]);
            end
        end
        step(4'b0000, 1'b0);
    endtask

    task automatic test_no_preempt;
        step(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b1001, 1'b0);
            total++;
            if (gnt !== 4'b0001) begin
                bad++;
                $display("FAIL no_preempt cyc=%0d got gnt=%b exp 0001", i, gnt);
            end
        end
        step(4'b1000, 1'b0);
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL preempt_gap got gnt=%b exp 0000", gnt);
        end
        step(4'b1000, 1'b0);
        total++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            bad++;
            $display("FAIL preempt_next got gnt=%b id=%0d exp 1000 id=3", gnt, gnt_id);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    task automatic test_timeout;
        int held = 0;
        step(4'b1001, 1'b0);
        while (gnt === 4'b1000 && held < 20) begin
            held++;
            total++;
            if (timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_early cyc=%0d got to=%b exp 0", held, timeout);
            end
            step(4'b1001, 1'b0);
        end
        total++;
        if (held != MAX_HOLD || gnt !== 4'b0000 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold got held=%0d gnt=%b to=%b exp held=%0d gnt=0000 to=1",
                     held, gnt, timeout, MAX_HOLD);
        end
        step(4'b1001, 1'b0);
        total++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_mask got gnt=%b to=%b exp 0001 to=0", gnt, timeout);
        end
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_regain got gnt=%b exp 1000", gnt);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    task automatic test_sole_masked;
        step(4'b0010, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) step(4'b0010, 1'b0);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL sole_last_cycle got gnt=%b exp 0010", gnt);
        end
        step(4'b0010, 1'b0);
        total++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL sole_timeout got gnt=%b to=%b exp 0000 to=1", gnt, timeout);
        end
        step(4'b0010, 1'b0);
        total++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL sole_regrant got gnt=%b id=%0d to=%b exp 0010 id=1 to=0", gnt, gnt_id, timeout);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL mid_pre got gnt=%b exp 0100", gnt);
        end
        step(4'b0100, 1'b1);
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got gnt=%b v=%b to=%b exp 0000 v=0 to=0", gnt, gnt_valid, timeout);
        end
        step(4'b0100, 1'b0);
        total++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_release got gnt=%b id=%0d v=%b exp 0100 id=2 v=1", gnt, gnt_id, gnt_valid);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    task automatic test_random;
        logic [3:0] r = 4'b0000;
        logic rs;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            rs = ($urandom_range(0, 79) == 0);
            step(r, rs);
            total++;
            if ({gnt, gnt_id, gnt_valid, timeout} !== {m_gnt, m_id, |m_gnt, m_to}) begin
                bad++;
                $display("FAIL random cyc=%0d req=%b got gnt=%b id=%0d v=%b to=%b exp gnt=%b id=%0d v=%b to=%b",
                         i, r, gnt, gnt_id, gnt_valid, timeout, m_gnt, m_id, |m_gnt, m_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_req();
        test_no_preempt();
        test_timeout();
        test_sole_masked();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
